// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main control FSM.
//
// Sequences FETCH/DECODE/EXEC/MEM/WB from the IR opcode and drives the datapath enables,
// the PC-select mux and the PC load enable. Moore outputs decode from the state register;
// only IllegalOp (Opcode) and PCEn (Zero) also depend on inputs in the current cycle.
//
// Optional feature: define MC_CTRL_BNE_EN to accept bne (000101). A flag latched in
// DECODE inverts the branch condition for the following BRANCH state.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   Opcode[5:0]  in   IR[31:26]
//   Zero         in   ALU zero flag
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  conditional (branch) PC load
//   PCEn         out  final PC load enable
//   PCSource     out  00 ALU, 01 ALUOut, 10 jump address
//   IorD         out  memory address select (0 PC, 1 ALUOut)
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IRWrite      out  IR load
//   MemtoReg     out  register write data select (0 ALUOut, 1 MDR)
//   RegDst       out  write register select (0 rt, 1 rd)
//   RegWrite     out  register file write strobe
//   ALUSrcA      out  ALU A select (0 PC, 1 regA)
//   ALUSrcB      out  ALU B select (00 regB, 01 4, 10 sext imm, 11 sext imm << 2)
//   ALUOp        out  00 add, 01 sub, 10 funct
//   IllegalOp    out  pulse in DECODE for an unsupported opcode
//   State        out  current state code

module mips_mc_control #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCEn,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        StReset  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRComp  = 4'd7,
        StRWb    = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StAddiEx = 4'd11,
        StAddiWb = 4'd12
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    state_e state_q, state_d;
    logic   branch_taken;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MC_CTRL_BNE_EN
    logic bne_q, bne_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bne_q <= 1'b0;
        end else begin
            bne_q <= bne_d;
        end
    end

    always_comb begin
        bne_d = bne_q;
        if (state_q == StFetch) begin
            bne_d = 1'b0;
        end else if (state_q == StDecode) begin
            bne_d = (Opcode == OpBne);
        end
    end

    assign branch_taken = bne_q ? ~Zero : Zero;
`else
    assign branch_taken = Zero;
`endif

    always_comb begin
        state_d     = StReset;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        IllegalOp   = 1'b0;

        case (state_q)
            StReset: begin
                state_d = StFetch;
            end
            StFetch: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB = 2'b11;
                case (Opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StRComp;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
`ifdef MC_CTRL_BNE_EN
                    OpBne:      state_d = StBranch;
`endif
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = StFetch;
            end
            StRComp: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = StRWb;
            end
            StRWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = StFetch;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = StFetch;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            default: begin
                // Unreachable codes recover through RESET with all outputs low.
                state_d = StReset;
            end
        endcase

        PCEn = PCWrite | (PCWriteCond & branch_taken);
    end

    assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: self-checking bench for mips_mc_control.
// A behavioural model expands each opcode into its expected state walk and derives the
// control word for each step; Zero and opcodes are randomized.

module tb_mips_mc_control;

`ifdef MC_CTRL_BNE_EN
    localparam bit BneEn = 1'b1;
`else
    localparam bit BneEn = 1'b0;
`endif

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rwr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       ill;
    } ctl_t;

    logic       Clk;
    logic       Reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PCWrite, PCWriteCond, PCEn;
    logic [1:0] PCSource;
    logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       IllegalOp;
    logic [3:0] State;

    ctl_t got;
    assign got = {PCWrite, PCWriteCond, PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, IllegalOp};

    int checks = 0;
    int errors = 0;
    int exp_seq[$];

    mips_mc_control #(.STATE_W(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCEn       (PCEn),
        .PCSource   (PCSource),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .IllegalOp  (IllegalOp),
        .State      (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction-level model: which states an opcode visits, FETCH first.
    task automatic build_seq(input logic [5:0] op);
        exp_seq = {1, 2};
        case (op)
            6'b100011: exp_seq = {exp_seq, 3, 4, 5};
            6'b101011: exp_seq = {exp_seq, 3, 6};
            6'b000000: exp_seq = {exp_seq, 7, 8};
            6'b000100: exp_seq.push_back(9);
            6'b000010: exp_seq.push_back(10);
            6'b001000: exp_seq = {exp_seq, 11, 12};
            6'b000101: if (BneEn) exp_seq.push_back(9);
            default: ;
        endcase
    endtask

    function automatic ctl_t model_ctl(input int st, input bit illegal, input logic z,
                                       input bit is_bne);
        ctl_t c;
        c = '0;
        case (st)
            1:  begin c.mrd = 1; c.irw = 1; c.srcb = 2'b01; c.pcw = 1; end
            2:  begin c.srcb = 2'b11; c.ill = illegal; end
            3:  begin c.srca = 1; c.srcb = 2'b10; end
            4:  begin c.mrd = 1; c.iord = 1; end
            5:  begin c.rwr = 1; c.m2r = 1; end
            6:  begin c.mwr = 1; c.iord = 1; end
            7:  begin c.srca = 1; c.aluop = 2'b10; end
            8:  begin c.rwr = 1; c.rdst = 1; end
            9:  begin
                    c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01;
                    c.pcen = is_bne ? ~z : z;
                end
            10: begin c.pcw = 1; c.pcsrc = 2'b10; end
            11: begin c.srca = 1; c.srcb = 2'b10; end
            12: begin c.rwr = 1; end
            default: ;
        endcase
        if (c.pcw) c.pcen = 1'b1;
        return c;
    endfunction

    // Precondition: 1 time unit after a posedge that entered FETCH. Leaves the same way.
    // zmode: 0 -> Zero=0, 1 -> Zero=1, 2 -> random.
    task automatic run_instr(input logic [5:0] op, input int zmode, input string name);
        ctl_t exp;
        bit   illegal;
        bit   is_bne;
        build_seq(op);
        illegal = (exp_seq.size() == 2);
        is_bne  = BneEn && (op == 6'b000101);
        for (int i = 0; i < exp_seq.size(); i++) begin
            Opcode = op;
            Zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge Clk);
            exp = model_ctl(exp_seq[i], illegal, Zero, is_bne);
            checks++;
            if (State !== 4'(exp_seq[i])) begin
                errors++;
                $display("FAIL %s state op=%b step=%0d got=%0d exp=%0d",
                         name, op, i, State, exp_seq[i]);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s ctl op=%b step=%0d z=%b got=%h exp=%h",
                         name, op, i, Zero, got, exp);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Opcode = 6'b000000;
        Zero   = 1'b0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            Zero = 1'($urandom_range(0, 1));
            @(negedge Clk);
            checks++;
            if (State !== 4'd0 || got !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got_state=%0d got_ctl=%h exp=0/0",
                         i, State, got);
            end
            @(posedge Clk);
            #1;
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if (State !== 4'd1 || !(MemRead && IRWrite && PCWrite && PCEn)) begin
            errors++;
            $display("FAIL reset_release got_state=%0d mr=%b irw=%b pcw=%b pcen=%b exp=1/1111",
                     State, MemRead, IRWrite, PCWrite, PCEn);
        end
        // Back up to the start of FETCH through a short reset so run_instr can start.
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 2, "lw");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 1, "beq_taken");
        run_instr(6'b000100, 0, "beq_not_taken");
    endtask

    task automatic test_jump();
        run_instr(6'b000010, 2, "jump");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 2, "illegal");
    endtask

    task automatic test_bne();
        run_instr(6'b000101, 0, "bne_z0");
        run_instr(6'b000101, 1, "bne_z1");
        // Flag must not leak into a following beq.
        run_instr(6'b000100, 1, "beq_after_bne");
    endtask

    task automatic test_reset_mid();
        Opcode = 6'b100011;
        Zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
        checks++;
        if (State !== 4'd4) begin
            errors++;
            $display("FAIL reset_mid_pre got=%0d exp=4", State);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if (State !== 4'd0 || got !== '0) begin
            errors++;
            $display("FAIL reset_mid got_state=%0d got_ctl=%h regwrite=%b exp=0/0",
                     State, got, RegWrite);
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        run_instr(6'b000000, 2, "after_reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b000101};
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7) op = ops[$urandom_range(0, 6)];
            else op = 6'($urandom_range(0, 63));
            run_instr(op, 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_jump();
        test_illegal();
        test_bne();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
